btn_toggle_pulse: RTL and testbench

Upstream conditioning stage for the T flip-flop. It takes a raw, asynchronous, bouncing push-button level and synchronizes and debounces it. For every debounced press (low-to-high) it emits exactly one single-cycle pulse on t_out, which drives the T input of the toggle flip-flop directly. It also exports the debounced level for LEDs and other consumers.

---
 rtl/btn_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/btn_toggle_pulse.sv | 98 +++++++++
 tb/tb_btn_toggle_pulse.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning path.
package btn_pkg;

  localparam int DEFAULT_CNT_MAX = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  function automatic logic is_qualifying(input btn_state_e st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_toggle_pulse.sv
// Synchronizes and debounces a raw button; one t_out pulse per accepted press.
module btn_toggle_pulse
  import btn_pkg::*;
#(
  parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level,
  output logic busy
);

  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_d, level_d, busy_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_out     <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_out     <= t_d;
      btn_level <= level_d;
      busy      <= busy_d;
    end
  end

  // The counter stops at CNT_LAST because the state always leaves on that compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    level_d = btn_level;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          t_d     = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = is_qualifying(state_d);
  end

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Bench for btn_toggle_pulse: vector table plus reset corner sequences.
module tb_btn_toggle_pulse;

  localparam int CNT_MAX = 4;
  localparam int LAT     = CNT_MAX + 3;

  typedef struct {
    logic btn;
    int   hold;
    logic push;
    logic exp_level;
    logic exp_busy;
  } vec_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic btn_in = 1'b0;
  logic t_out, btn_level, busy;

  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          pulse_cnt = 0;
  logic        tff_q     = 1'b0;
  logic        prev_t    = 1'b0;
  logic [31:0] exp_q[$];
  vec_t        tbl[$];

  btn_toggle_pulse #(.CNT_MAX(CNT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .t_out     (t_out),
    .btn_level (btn_level),
    .busy      (busy)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: each observed pulse pops one expected cycle; T flip-flop model downstream
  always @(negedge clk) begin
    if (!rst) begin
      tff_q = 1'b0;
    end else if (t_out) begin
      pulse_cnt++;
      tff_q = ~tff_q;
      check("t_out_not_back_to_back", {31'd0, prev_t}, 0);
      if (exp_q.size() == 0) check("pulse_expected", 0, 1);
      else check("pulse_cycle", cyc, exp_q.pop_front());
    end
    if (exp_q.size() != 0 && exp_q[0] < cyc) begin
      check("pulse_missing", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
    prev_t = t_out;
  end

  // driver tasks
  task automatic add(input logic b, input int h, input logic p, input logic l, input logic bz);
    vec_t v;
    v.btn = b; v.hold = h; v.push = p; v.exp_level = l; v.exp_busy = bz;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    btn_in = v.btn;
    if (v.push) exp_q.push_back(cyc + LAT);
    repeat (v.hold) @(negedge clk);
    check($sformatf("vec%0d_level", idx), {31'd0, btn_level}, {31'd0, v.exp_level});
    check($sformatf("vec%0d_busy", idx), {31'd0, busy}, {31'd0, v.exp_busy});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_t_out"}, {31'd0, t_out}, 0);
    check({tag, "_level"}, {31'd0, btn_level}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int base;
    vec_t pr, rl;
    // clean press, then clean release
    add(1, 3, 1, 0, 1); add(1, 3, 0, 0, 1); add(1, 1, 0, 1, 0); add(1, 5, 0, 1, 0);
    add(0, 3, 0, 1, 1); add(0, 3, 0, 1, 1); add(0, 1, 0, 0, 0); add(0, 4, 0, 0, 0);
    // press bounce: 1,1,0 then held
    add(1, 2, 0, 0, 0); add(0, 1, 0, 0, 1); add(1, 2, 1, 0, 0); add(1, 5, 0, 1, 0);
    // release bounce: 0,0 then back to 1
    add(0, 2, 0, 1, 0); add(1, 1, 0, 1, 1); add(1, 2, 0, 1, 0); add(1, 5, 0, 1, 0);
    // clean release
    add(0, 3, 0, 1, 1); add(0, 3, 0, 1, 1); add(0, 1, 0, 0, 0); add(0, 4, 0, 0, 0);

    // reset
    #1 rst = 1'b0;
    #1 check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) apply(tbl[i], i);

    // three 20-cycle press/release cycles
    base = pulse_cnt;
    pr.btn = 1; pr.hold = 10; pr.push = 1; pr.exp_level = 1; pr.exp_busy = 0;
    rl.btn = 0; rl.hold = 10; rl.push = 0; rl.exp_level = 0; rl.exp_busy = 0;
    for (int k = 0; k < 3; k++) begin
      apply(pr, 100 + 2 * k);
      apply(rl, 101 + 2 * k);
    end
    check("repeat_pulse_count", pulse_cnt - base, 3);
    check("tff_q_after_3", {31'd0, tff_q}, 1);

    // reset mid-qualification (WAIT_HIGH, cnt=2)
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT - 1) @(negedge clk);
    check("mid_requal_level_early", {31'd0, btn_level}, 0);
    @(negedge clk);
    check("mid_requal_level", {31'd0, btn_level}, 1);
    btn_in = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("mid_released_level", {31'd0, btn_level}, 0);

    // reset while t_out is high
    btn_in = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    @(posedge clk);
    #1 check("pulse_before_rst", {31'd0, t_out}, 1);
    rst = 1'b0;
    #1 check_all_zero("pulse_rst_async");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (LAT - 1) @(negedge clk);
    check("no_early_pulse", {31'd0, t_out}, 0);
    check("no_early_level", {31'd0, btn_level}, 0);
    @(negedge clk);
    check("fresh_pulse_level", {31'd0, btn_level}, 1);
    btn_in = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    check("final_level", {31'd0, btn_level}, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
